// File: rtl/siso_ctrl_pkg.sv
// Shared types for the shift-register controller: FSM state and done_src codes.
package siso_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SRC_REQ0   = 2'b01;
  localparam logic [1:0] SRC_REQ1   = 2'b10;
  localparam logic [1:0] SRC_PRESET = 2'b11;

endpackage

// File: rtl/siso_shift_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; after a grant is consumed the other requester is preferred.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  // ptr_q = 0 prefers req[0], 1 prefers req[1]
  logic ptr_q;

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || !ptr_q)) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else if (adv) begin
      ptr_q <= gnt[0];
    end
  end

endmodule

// File: rtl/siso_shift_ctrl.sv
// Shares one serial-in shift register between two requesters: arbitrate, shift MSB-first, read back.
// Optional preset path enabled by defining SISO_CTRL_PRESET_EN.
module siso_shift_ctrl
  import siso_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sr_data_in,
  output logic             sr_enable,
  output logic             sr_set_all_ones,
  input  logic [WIDTH-1:0] sr_data_out,
`ifdef SISO_CTRL_PRESET_EN
  input  logic             preset_req,
`endif
  output logic             busy,
  output logic             done,
  output logic [1:0]       done_src,
  output logic [WIDTH-1:0] result,
  output logic             match
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] bit_idx;
  logic [WIDTH-1:0] word_q;
  logic [1:0]       src_q;
  logic [WIDTH-1:0] result_q;
  logic             match_q;
  logic [1:0]       arb_gnt;
  logic             arb_adv;
  logic             preset_go;
  logic             idle_open;
  logic             shift_last;

`ifdef SISO_CTRL_PRESET_EN
  assign preset_go = preset_req;
`else
  assign preset_go = 1'b0;
`endif

  // Readies are withheld during reset and while a preset claims the register.
  assign idle_open  = (state_q == IDLE) && !reset && !preset_go;
  assign req0_ready = idle_open && arb_gnt[0];
  assign req1_ready = idle_open && arb_gnt[1];
  assign arb_adv    = req0_ready || req1_ready;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({req1_valid, req0_valid}),
    .adv   (arb_adv),
    .gnt   (arb_gnt)
  );

  assign shift_last = (src_q == SRC_PRESET) || (cnt_q == CNT_W'(WIDTH - 1));
  assign bit_idx    = CNT_W'(WIDTH - 1) - cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (preset_go || arb_adv) state_d = SHIFT;
      SHIFT:   if (shift_last) state_d = CHECK;
      CHECK:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      src_q    <= 2'b00;
      result_q <= '0;
      match_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (preset_go) begin
            src_q <= SRC_PRESET;
          end else if (arb_adv) begin
            src_q <= req0_ready ? SRC_REQ0 : SRC_REQ1;
          end
        end
        SHIFT: if (!shift_last) cnt_q <= cnt_q + 1'b1;
        CHECK: begin
          result_q <= sr_data_out;
          match_q  <= (sr_data_out == word_q);
        end
        default: ;
      endcase
    end
  end

  // Expected word is pure data; it is only consumed after being loaded.
  always_ff @(posedge clk) begin
    if (state_q == IDLE) begin
      if (preset_go) begin
        word_q <= '1;
      end else if (req0_ready) begin
        word_q <= req0_data;
      end else if (req1_ready) begin
        word_q <= req1_data;
      end
    end
  end

  assign sr_enable  = (state_q == SHIFT);
  assign sr_data_in = (state_q == SHIFT) && word_q[bit_idx];
`ifdef SISO_CTRL_PRESET_EN
  assign sr_set_all_ones = (state_q == SHIFT) && (src_q == SRC_PRESET);
`else
  assign sr_set_all_ones = 1'b0;
`endif

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign done_src = src_q;
  assign result   = result_q;
  assign match    = match_q;

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Randomised self-checking bench for siso_shift_ctrl with a transaction-level reference model.
module tb_siso_shift_ctrl;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         v0, v1, pre, force0;
  logic [W-1:0] d0, d1;
  logic         r0, r1;
  logic         sr_din, sr_en, sr_set;
  logic [W-1:0] sr_q, sr_dout;
  logic         busy, done, match;
  logic [1:0]   done_src;
  logic [W-1:0] result;

  int n_chk = 0;
  int n_err = 0;

  siso_shift_ctrl #(.WIDTH(W)) dut (
    .clk             (clk),
    .reset           (rst),
    .req0_valid      (v0),
    .req0_data       (d0),
    .req0_ready      (r0),
    .req1_valid      (v1),
    .req1_data       (d1),
    .req1_ready      (r1),
    .sr_data_in      (sr_din),
    .sr_enable       (sr_en),
    .sr_set_all_ones (sr_set),
    .sr_data_out     (sr_dout),
`ifdef SISO_CTRL_PRESET_EN
    .preset_req      (pre),
`endif
    .busy            (busy),
    .done            (done),
    .done_src        (done_src),
    .result          (result),
    .match           (match)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural shift register the controller drives; force0 models a stuck readback.
  always @(posedge clk) begin
    if (rst) sr_q <= '0;
    else if (sr_set) sr_q <= '1;
    else if (sr_en) sr_q <= {sr_q[W-2:0], sr_din};
  end
  assign sr_dout = force0 ? '0 : sr_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: t = position within the current transaction (0 = idle),
  // L = number of shift cycles, done appears at position L+2.
  int           m_t = 0;
  int           m_len = W;
  logic [W-1:0] m_word = '0;
  logic [1:0]   m_src = 2'b00;
  logic         m_pref = 1'b0;
  logic [W-1:0] m_res = '0;
  logic         m_match = 1'b0;
  logic         m_src_zero = 1'b1;

  always @(negedge clk) begin : model
    logic pp, g0, g1, e_r0, e_r1, e_en, e_set, e_din, e_done;
    pp = 1'b0;
`ifdef SISO_CTRL_PRESET_EN
    pp = pre;
`endif
    g0 = v0 && (!v1 || !m_pref);
    g1 = v1 && !g0;
    e_r0 = (m_t == 0) && !rst && !pp && g0;
    e_r1 = (m_t == 0) && !rst && !pp && g1;
    e_en = (m_t != 0) && (m_t <= m_len);
    e_set = e_en && (m_src == 2'b11);
    e_din = e_en && m_word[W - m_t];
    e_done = (m_t != 0) && (m_t == m_len + 2);

    check("req0_ready", r0, e_r0);
    check("req1_ready", r1, e_r1);
    check("ready_onehot", r0 & r1, 1'b0);
    check("sr_enable", sr_en, e_en);
    check("sr_set_all_ones", sr_set, e_set);
    check("sr_data_in", sr_din, e_din);
    check("busy", busy, m_t != 0);
    check("done", done, e_done);
    check("result", result, m_res);
    check("match", match, m_match);
    if (e_done) check("done_src", done_src, m_src);
    if (m_src_zero) check("done_src_reset", done_src, 2'b00);

    if (rst) begin
      m_t = 0; m_pref = 1'b0; m_res = '0; m_match = 1'b0; m_src_zero = 1'b1;
    end else if (m_t == 0) begin
      if (pp) begin
        m_t = 1; m_len = 1; m_word = '1; m_src = 2'b11; m_src_zero = 1'b0;
      end else if (e_r0) begin
        m_t = 1; m_len = W; m_word = d0; m_src = 2'b01; m_pref = 1'b1; m_src_zero = 1'b0;
      end else if (e_r1) begin
        m_t = 1; m_len = W; m_word = d1; m_src = 2'b10; m_pref = 1'b0; m_src_zero = 1'b0;
      end
    end else begin
      if (m_t == m_len + 1) begin
        m_res = force0 ? '0 : m_word;
        m_match = (m_res == m_word);
      end
      m_t = (m_t == m_len + 2) ? 0 : m_t + 1;
    end
  end

  task automatic send(input int idx, input logic [W-1:0] data);
    logic got;
    @(posedge clk); #1;
    if (idx == 0) begin v0 = 1'b1; d0 = data; end
    else begin v1 = 1'b1; d1 = data; end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((idx == 0) ? r0 : r1) begin got = 1'b1; break; end
    end
    check("send_grant", got, 1'b1);
    @(posedge clk); #1;
    if (idx == 0) v0 = 1'b0; else v1 = 1'b0;
  endtask

  // Called in cycle 1 of a transaction; counts cycles until done (accept cycle = 0).
  task automatic wait_done(input int exp_lat, input logic [1:0] exp_src,
                           input logic [W-1:0] exp_res, input logic exp_match);
    int lat;
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      if (i > 1) @(negedge clk);
      else @(negedge clk);
      if (done) begin lat = i; break; end
    end
    check("done_latency", lat, exp_lat);
    check("done_src_value", done_src, exp_src);
    check("done_result", result, exp_res);
    check("done_match", match, exp_match);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    int acc_src[$];
    int acc_cyc[$];
    logic hs0, hs1;
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; pre = 1'b0; force0 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single req0 word, MSB-first shifting
    send(0, 4'b1011);
    wait_done(W + 2, 2'b01, 4'b1011, 1'b1);

    // Both valid continuously: alternating accepts W+3 cycles apart
    pulse_reset();
    @(posedge clk); #1;
    v0 = 1'b1; d0 = 4'h3; v1 = 1'b1; d1 = 4'hC;
    for (int c = 0; c < 23; c++) begin
      @(negedge clk);
      if (v0 && r0) begin acc_src.push_back(1); acc_cyc.push_back(c); end
      if (v1 && r1) begin acc_src.push_back(2); acc_cyc.push_back(c); end
    end
    @(posedge clk); #1 v0 = 1'b0; v1 = 1'b0;
    check("rr_count", acc_src.size() >= 3, 1'b1);
    if (acc_src.size() >= 3) begin
      check("rr_first", acc_src[0], 1);
      check("rr_second", acc_src[1], 2);
      check("rr_third", acc_src[2], 1);
      check("rr_gap1", acc_cyc[1] - acc_cyc[0], W + 3);
      check("rr_gap2", acc_cyc[2] - acc_cyc[1], W + 3);
    end
    repeat (W + 4) @(posedge clk);

    // Readback stuck at zero
    force0 = 1'b1;
    send(1, 4'hF);
    wait_done(W + 2, 2'b10, 4'h0, 1'b0);
    @(posedge clk); #1 force0 = 1'b0;

    // Reset in SHIFT cycle 2 abandons the word
    send(0, 4'h5);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_sr_enable", sr_en, 1'b0);
    check("rst_result", result, 4'h0);
    check("rst_done_src", done_src, 2'b00);
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      check("rst_no_done", done, 1'b0);
    end
    @(posedge clk); #1 v0 = 1'b1; d0 = 4'h9; v1 = 1'b1; d1 = 4'h6;
    @(negedge clk);
    check("rst_ptr_req0", r0, 1'b1);
    check("rst_ptr_not_req1", r1, 1'b0);
    @(posedge clk); #1 v0 = 1'b0; v1 = 1'b0;
    repeat (W + 4) @(posedge clk);

    // Lone req1 twice in a row
    send(1, 4'hA);
    wait_done(W + 2, 2'b10, 4'hA, 1'b1);
    send(1, 4'h6);
    wait_done(W + 2, 2'b10, 4'h6, 1'b1);

    // req0 withdraws before being granted
    send(1, 4'h9);
    v0 = 1'b1; d0 = 4'h7;
    repeat (3) @(posedge clk);
    #1 v0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) break;
    end
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      check("drop_no_enable", sr_en, 1'b0);
      check("drop_no_busy", busy, 1'b0);
    end

`ifdef SISO_CTRL_PRESET_EN
    // Preset wins over req0, then req0 follows
    @(posedge clk); #1 pre = 1'b1; v0 = 1'b1; d0 = 4'h2;
    @(negedge clk);
    check("preset_blocks_ready", r0, 1'b0);
    @(posedge clk); #1 pre = 1'b0;
    @(negedge clk);
    check("preset_set_all_ones", sr_set, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("preset_done", done, 1'b1);
    check("preset_src", done_src, 2'b11);
    check("preset_result", result, 4'hF);
    check("preset_match", match, 1'b1);
    @(negedge clk);
    check("preset_then_req0", r0, 1'b1);
    @(posedge clk); #1 v0 = 1'b0;
    repeat (W + 4) @(posedge clk);
`endif

    // Random traffic, checked cycle by cycle by the model
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      hs0 = v0 && r0;
      hs1 = v1 && r1;
      @(posedge clk); #1;
      if (hs0 || !v0) begin v0 = ($urandom_range(0, 1) == 1); d0 = W'($urandom); end
      else if ($urandom_range(0, 7) == 0) v0 = 1'b0;
      if (hs1 || !v1) begin v1 = ($urandom_range(0, 1) == 1); d1 = W'($urandom); end
      else if ($urandom_range(0, 7) == 0) v1 = 1'b0;
      rst = ($urandom_range(0, 99) == 0);
`ifdef SISO_CTRL_PRESET_EN
      pre = ($urandom_range(0, 15) == 0);
`endif
      if ($urandom_range(0, 19) == 0) force0 = !force0;
    end
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0; pre = 1'b0;
    repeat (W + 4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/siso_shift_ctrl.md
# siso_shift_ctrl

Controller that shares one WIDTH-bit serial-in shift register between two parallel-word requesters. Arbitrates round-robin, serialises the granted word MSB-first into the register's `data_in` and `enable` pins, then reads back the register's `data_out` and reports completion with a match flag. Sits directly in front of the shift register instance; the shift register's own `reset` is driven from the same `reset` net.

## Interface
- `WIDTH`, 4, word and shift-register width (≥2)
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `req0_valid` in 1 / `req0_data` in WIDTH / `req0_ready` out 1: requester 0 handshake
- `req1_valid` in 1 / `req1_data` in WIDTH / `req1_ready` out 1: requester 1 handshake
- `sr_data_in` out 1: serial bit to shift register
- `sr_enable` out 1: shift-register enable
- `sr_set_all_ones` out 1: shift-register preset strobe
- `sr_data_out` in WIDTH: shift-register parallel readback
- `busy` out 1: high when not IDLE
- `done` out 1: one-cycle completion pulse
- `done_src` out 2: 01 = req0, 10 = req1, 11 = preset
- `result` out WIDTH: captured readback; valid while `done`
- `match` out 1: `result` equals the expected word; valid while `done`
- `preset_req` in 1: preset request (only with `SISO_CTRL_PRESET_EN`)

## Operation
- FSM states: IDLE, SHIFT, CHECK, DONE.
- **IDLE**
  - Arbiter grants one valid requester; only the granted requester sees `reqN_ready` = 1 (combinational from valid and the pointer).
  - On `valid && ready`: latch the word as expected value, record the source, clear bit counter, go to SHIFT.
- **Arbitration**
  - Round-robin pointer names the preferred requester; after reset it is req0.
  - Pointer moves to the other requester after each accepted transfer.
  - A lone valid requester is always granted.
- **SHIFT**
  - `sr_enable` = 1 and `sr_data_in` = word[WIDTH-1-cnt].
  - cnt increments each cycle; when cnt = WIDTH-1, go to CHECK.
  - No ready is asserted while SHIFT is active.
- **CHECK**
  - `sr_enable` = 0.
  - Capture `sr_data_out` into `result`; compute `match`. Go to DONE.
- **DONE**
  - `done` = 1 for exactly one cycle, together with `done_src`, `result` and `match`. Go to IDLE.
- `result`/`match` hold their value until the next CHECK.
- A requester must hold valid and data stable until ready. Valid dropped before ready is legal; that requester is simply not granted.
- Counter width is $clog2(WIDTH); cnt never exceeds WIDTH-1.
- Reset at any point:
  - state to IDLE, pointer to req0.
  - All outputs to 0: readies, `sr_*`, `busy`, `done`, `done_src`, `result`, `match`.
  - A partially shifted word is abandoned and no `done` is issued.

## Timing
- Accept in cycle 0.
- `sr_enable` is high during cycles 1..WIDTH; the register holds the word after the cycle-WIDTH edge.
- CHECK runs in cycle WIDTH+1; `done` is high in cycle WIDTH+2.
- Earliest next accept is in cycle WIDTH+3. Throughput is one word per WIDTH+3 cycles.
- `busy` is high during cycles 1..WIDTH+2.
- `sr_*` outputs are registered or decoded from state/counter only; there is no combinational path from `reqN_valid` to `sr_*`.

## Configuration
- `SISO_CTRL_PRESET_EN` defined:
  - `preset_req` port exists; in IDLE it has priority over both requesters and does not move the pointer.
  - A preset runs one SHIFT cycle with `sr_enable` = `sr_set_all_ones` = 1 and expected word all ones, then CHECK and DONE.
  - `done_src` = 11; latency is `done` in cycle 3.
- Undefined: `preset_req` port is absent and `sr_set_all_ones` is tied to 0.

## Structure
- Package `siso_ctrl_pkg`:
  - state enum (IDLE/SHIFT/CHECK/DONE);
  - `done_src` constants SRC_REQ0 = 2'b01, SRC_REQ1 = 2'b10, SRC_PRESET = 2'b11.
- Sub-module `rr_arb2`: two-way round-robin arbiter with request inputs, grant outputs, an advance strobe and the pointer register.

## Test plan
- WIDTH=4, req0 sends 4'b1011 → `sr_data_in` 1,0,1,1 in cycles 1–4 with `sr_enable` high; `done` in cycle 6 with `done_src` = 01, `result` = 1011, `match` = 1.
- Both valid continuously, req0 = 4'h3, req1 = 4'hC → accept order req0, req1, req0. Accepts are 7 cycles apart; readies are never both high.
- `sr_data_out` forced to 4'h0 while req1 sends 4'hF → `done` with `result` = 0, `match` = 0, `done_src` = 10.
- `reset` in cycle 2 of SHIFT → next cycle all outputs are 0, no `done` pulse, pointer back to req0.
- req1 alone valid after a req1 transfer → still granted. req0 drops valid before grant → no accept, no `sr_enable`.
- With `SISO_CTRL_PRESET_EN`, `preset_req` and req0 valid together → preset first: one cycle with `sr_set_all_ones`, `done` in cycle 3 with `result` = 4'hF, `match` = 1, `done_src` = 11; req0 accepted afterwards.
